kyber_bram_packer: RTL and testbench

KYBER_BRAM_PACKER -- requirements
Module: kyber_bram_packer

---
 rtl/kyber_bram_packer.sv | 182 ++++++++++++++++++
 tb/tb_kyber_bram_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_bram_packer.sv
// Packs 32-bit input beats into 128-bit words and writes them to consecutive
// BRAM addresses starting at base_addr. All outputs come straight from flops.
module kyber_bram_packer #(
  parameter int ADDR_W = 8
) (
  input  logic              reg_clk,
  input  logic              reg_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_words,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr_br,
  output logic              en_br,
  output logic [15:0]       we_br,
  output logic [127:0]      wrdata_br,
  output logic              busy,
  output logic              done,
  output logic [7:0]        words_written
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r,     state_next_s;
  logic [ADDR_W-1:0]   base_r,      base_next_s;
  logic [7:0]          num_r,       num_next_s;
  logic [7:0]          idx_r,       idx_next_s;
  logic [1:0]          lane_r,      lane_next_s;
  logic [95:0]         lanes_r,     lanes_next_s;
  logic [ADDR_W-1:0]   addr_r,      addr_next_s;
  logic [127:0]        wrdata_r,    wrdata_next_s;
  logic [7:0]          ww_r,        ww_next_s;
  logic                s_ready_r,   s_ready_next_s;
  logic                en_r,        en_next_s;
  logic [15:0]         we_r,        we_next_s;
  logic                busy_r,      busy_next_s;
  logic                done_r,      done_next_s;
  logic [ADDR_W-1:0]   addr_sum_s;

  // Address arithmetic wraps naturally at the ADDR_W boundary.
  assign addr_sum_s = base_r + ADDR_W'(idx_r);

  // State, job, datapath and output registers with synchronous reset.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      state_r   <= ST_IDLE;
      base_r    <= '0;
      num_r     <= 8'd0;
      idx_r     <= 8'd0;
      lane_r    <= 2'd0;
      lanes_r   <= 96'd0;
      addr_r    <= '0;
      wrdata_r  <= 128'd0;
      ww_r      <= 8'd0;
      s_ready_r <= 1'b0;
      en_r      <= 1'b0;
      we_r      <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      base_r    <= base_next_s;
      num_r     <= num_next_s;
      idx_r     <= idx_next_s;
      lane_r    <= lane_next_s;
      lanes_r   <= lanes_next_s;
      addr_r    <= addr_next_s;
      wrdata_r  <= wrdata_next_s;
      ww_r      <= ww_next_s;
      s_ready_r <= s_ready_next_s;
      en_r      <= en_next_s;
      we_r      <= we_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
    end
  end

  // Next-state, lane packing and next output values.
  always_comb begin
    state_next_s  = state_r;
    base_next_s   = base_r;
    num_next_s    = num_r;
    idx_next_s    = idx_r;
    lane_next_s   = lane_r;
    lanes_next_s  = lanes_r;
    addr_next_s   = addr_r;
    wrdata_next_s = wrdata_r;
    ww_next_s     = ww_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          base_next_s  = base_addr;
          num_next_s   = num_words;
          idx_next_s   = 8'd0;
          lane_next_s  = 2'd0;
          lanes_next_s = 96'd0;
          ww_next_s    = 8'd0;
          if (num_words != 8'd0) begin
            state_next_s = ST_FILL;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (abort) begin
          state_next_s = ST_IDLE;
          lane_next_s  = 2'd0;
          lanes_next_s = 96'd0;
        end else if (s_valid) begin
          if (lane_r == 2'd3) begin
            // Fourth beat: the word goes out on the very next cycle.
            state_next_s  = ST_WRITE;
            lane_next_s   = 2'd0;
            wrdata_next_s = {s_data, lanes_r};
            addr_next_s   = addr_sum_s;
            ww_next_s     = ww_r + 8'd1;
          end else begin
            lane_next_s = lane_r + 2'd1;
            case (lane_r)
              2'd0:    lanes_next_s[31:0]  = s_data;
              2'd1:    lanes_next_s[63:32] = s_data;
              2'd2:    lanes_next_s[95:64] = s_data;
              default: lanes_next_s        = lanes_r;
            endcase
          end
        end else begin
          state_next_s = ST_FILL;
        end
      end

      ST_WRITE: begin
        if (abort) begin
          state_next_s = ST_IDLE;
          lane_next_s  = 2'd0;
          lanes_next_s = 96'd0;
        end else if (idx_r == num_r - 8'd1) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_FILL;
          idx_next_s   = idx_r + 8'd1;
          lane_next_s  = 2'd0;
        end
      end

      ST_DONE: begin
        state_next_s = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    s_ready_next_s = (state_next_s == ST_FILL);
    en_next_s      = (state_next_s == ST_WRITE);
    we_next_s      = (state_next_s == ST_WRITE) ? 16'hFFFF : 16'h0000;
    busy_next_s    = (state_next_s != ST_IDLE);
    done_next_s    = (state_next_s == ST_DONE);
  end

  assign s_ready       = s_ready_r;
  assign addr_br       = addr_r;
  assign en_br         = en_r;
  assign we_br         = we_r;
  assign wrdata_br     = wrdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign words_written = ww_r;

endmodule

// File: tb/tb_kyber_bram_packer.sv
// Directed bench for kyber_bram_packer: drives on the falling edge, samples
// outputs and logs BRAM writes / done pulses on the falling edge.
module tb_kyber_bram_packer;

  logic         reg_clk = 1'b0;
  logic         reg_rst;
  logic         start;
  logic         abort;
  logic [7:0]   base_addr;
  logic [7:0]   num_words;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   addr_br;
  logic         en_br;
  logic [15:0]  we_br;
  logic [127:0] wrdata_br;
  logic         busy;
  logic         done;
  logic [7:0]   words_written;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_hs = 0;

  logic [7:0]   wr_addr[$];
  logic [127:0] wr_data[$];
  logic [15:0]  wr_we[$];
  int           wr_cyc[$];
  int           done_cyc[$];

  kyber_bram_packer #(.ADDR_W(8)) dut (
    .reg_clk       (reg_clk),
    .reg_rst       (reg_rst),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .addr_br       (addr_br),
    .en_br         (en_br),
    .we_br         (we_br),
    .wrdata_br     (wrdata_br),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 reg_clk = ~reg_clk;

  always @(posedge reg_clk) cyc <= cyc + 1;

  // Log every BRAM write and done pulse, stamped with the edge that raised it.
  always @(negedge reg_clk) begin
    if (en_br) begin
      wr_addr.push_back(addr_br);
      wr_data.push_back(wrdata_br);
      wr_we.push_back(we_br);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_we.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_start(input logic [7:0] base, input logic [7:0] nw);
    @(negedge reg_clk);
    start     = 1'b1;
    base_addr = base;
    num_words = nw;
    @(negedge reg_clk);
    start     = 1'b0;
  endtask

  // Sends n beats first, first+1, ...; stall inserts an idle cycle after each.
  task automatic send_beats(input logic [31:0] first, input int n, input bit stall);
    int waits;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = first + 32'(i);
      waits   = 0;
      while (!s_ready && waits < 50) begin
        @(negedge reg_clk);
        waits++;
      end
      if (waits >= 50) check_eq("hs_timeout", 128'd1, 128'd0);
      @(negedge reg_clk);
      last_hs = cyc;
      if (stall) begin
        s_valid = 1'b0;
        @(negedge reg_clk);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    reg_rst   = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 8'd0;
    num_words = 8'd0;
    s_data    = 32'd0;
    s_valid   = 1'b0;
    repeat (3) @(negedge reg_clk);
    check_eq("rst_s_ready", 128'(s_ready), 128'd0);
    check_eq("rst_en",      128'(en_br),   128'd0);
    check_eq("rst_we",      128'(we_br),   128'd0);
    check_eq("rst_addr",    128'(addr_br), 128'd0);
    check_eq("rst_data",    wrdata_br,     128'd0);
    check_eq("rst_busy",    128'(busy),    128'd0);
    check_eq("rst_done",    128'(done),    128'd0);
    check_eq("rst_ww",      128'(words_written), 128'd0);
    reg_rst = 1'b0;

    // Two words back to back at base 52
    clear_log();
    do_start(8'd52, 8'd2);
    check_eq("bb_busy",    128'(busy),    128'd1);
    check_eq("bb_s_ready", 128'(s_ready), 128'd1);
    send_beats(32'd1, 8, 1'b0);
    repeat (3) @(negedge reg_clk);
    check_eq("bb_nwr", 128'(wr_addr.size()), 128'd2);
    if (wr_addr.size() >= 2) begin
      check_eq("bb_addr0", 128'(wr_addr[0]), 128'd52);
      check_eq("bb_data0", wr_data[0], 128'h00000004_00000003_00000002_00000001);
      check_eq("bb_we0",   128'(wr_we[0]), 128'hFFFF);
      check_eq("bb_addr1", 128'(wr_addr[1]), 128'd53);
      check_eq("bb_data1", wr_data[1], 128'h00000008_00000007_00000006_00000005);
      check_eq("bb_lat1",  128'(wr_cyc[1]), 128'(last_hs));
    end
    check_eq("bb_ndone", 128'(done_cyc.size()), 128'd1);
    if (done_cyc.size() >= 1 && wr_cyc.size() >= 2)
      check_eq("bb_done_cyc", 128'(done_cyc[0]), 128'(wr_cyc[1] + 1));
    check_eq("bb_ww",      128'(words_written), 128'd2);
    check_eq("bb_idle",    128'(busy),    128'd0);
    check_eq("bb_we_hold", 128'(we_br),   128'd0);
    check_eq("bb_addr_hold", 128'(addr_br), 128'd53);

    // Zero-length job
    clear_log();
    do_start(8'd9, 8'd0);
    check_eq("z_done",    128'(done),    128'd1);
    check_eq("z_busy",    128'(busy),    128'd1);
    check_eq("z_s_ready", 128'(s_ready), 128'd0);
    @(negedge reg_clk);
    check_eq("z_done_end", 128'(done), 128'd0);
    check_eq("z_busy_end", 128'(busy), 128'd0);
    check_eq("z_nwr",      128'(wr_addr.size()), 128'd0);
    check_eq("z_ww",       128'(words_written), 128'd0);

    // Address wrap from 255
    clear_log();
    do_start(8'd255, 8'd2);
    send_beats(32'h100, 8, 1'b0);
    repeat (3) @(negedge reg_clk);
    check_eq("wrap_nwr", 128'(wr_addr.size()), 128'd2);
    if (wr_addr.size() >= 2) begin
      check_eq("wrap_addr0", 128'(wr_addr[0]), 128'd255);
      check_eq("wrap_addr1", 128'(wr_addr[1]), 128'd0);
      check_eq("wrap_data1", wr_data[1], 128'h00000107_00000106_00000105_00000104);
    end

    // Toggling s_valid plus a long stall
    clear_log();
    do_start(8'd10, 8'd1);
    send_beats(32'd1, 2, 1'b1);
    s_valid = 1'b0;
    repeat (5) @(negedge reg_clk);
    check_eq("st_s_ready", 128'(s_ready), 128'd1);
    check_eq("st_busy",    128'(busy),    128'd1);
    check_eq("st_nwr0",    128'(wr_addr.size()), 128'd0);
    send_beats(32'd3, 2, 1'b1);
    repeat (3) @(negedge reg_clk);
    check_eq("st_nwr", 128'(wr_addr.size()), 128'd1);
    if (wr_addr.size() >= 1) begin
      check_eq("st_addr", 128'(wr_addr[0]), 128'd10);
      check_eq("st_data", wr_data[0], 128'h00000004_00000003_00000002_00000001);
      check_eq("st_lat",  128'(wr_cyc[0]), 128'(last_hs));
    end
    check_eq("st_ndone", 128'(done_cyc.size()), 128'd1);

    // Abort mid-word of a three-word job, then a clean job
    clear_log();
    do_start(8'd100, 8'd3);
    send_beats(32'h200, 6, 1'b0);
    abort = 1'b1;
    @(negedge reg_clk);
    abort = 1'b0;
    check_eq("ab_s_ready", 128'(s_ready), 128'd0);
    check_eq("ab_busy",    128'(busy),    128'd0);
    repeat (8) @(negedge reg_clk);
    check_eq("ab_nwr",   128'(wr_addr.size()), 128'd1);
    if (wr_addr.size() >= 1)
      check_eq("ab_data0", wr_data[0], 128'h00000203_00000202_00000201_00000200);
    check_eq("ab_ndone", 128'(done_cyc.size()), 128'd0);
    check_eq("ab_ww",    128'(words_written), 128'd1);
    clear_log();
    do_start(8'd7, 8'd1);
    send_beats(32'h300, 4, 1'b0);
    repeat (3) @(negedge reg_clk);
    check_eq("ab2_nwr", 128'(wr_addr.size()), 128'd1);
    if (wr_addr.size() >= 1) begin
      check_eq("ab2_addr", 128'(wr_addr[0]), 128'd7);
      check_eq("ab2_data", wr_data[0], 128'h00000303_00000302_00000301_00000300);
    end
    check_eq("ab2_ndone", 128'(done_cyc.size()), 128'd1);
    check_eq("ab2_ww",    128'(words_written), 128'd1);

    // Reset during the write of word 0
    clear_log();
    do_start(8'd20, 8'd2);
    send_beats(32'h400, 4, 1'b0);
    check_eq("rw_en_before", 128'(en_br), 128'd1);
    reg_rst = 1'b1;
    @(negedge reg_clk);
    check_eq("rw_en",      128'(en_br),   128'd0);
    check_eq("rw_we",      128'(we_br),   128'd0);
    check_eq("rw_addr",    128'(addr_br), 128'd0);
    check_eq("rw_data",    wrdata_br,     128'd0);
    check_eq("rw_busy",    128'(busy),    128'd0);
    check_eq("rw_s_ready", 128'(s_ready), 128'd0);
    check_eq("rw_ww",      128'(words_written), 128'd0);
    reg_rst = 1'b0;
    repeat (8) @(negedge reg_clk);
    check_eq("rw_nwr",   128'(wr_addr.size()), 128'd1);
    check_eq("rw_ndone", 128'(done_cyc.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
